truth_table_sweeper: RTL and testbench

- Synthesizable stimulus sequencer and response capture for 3-input combinational blocks such as `example`.
- Drives `x1`, `x2`, `x3` through all 8 combinations, 000 to 111, holding each for `HOLD_CYCLES` clocks.
- Samples the block's output `f` once per combination and assembles an 8-bit truth-table signature.
- Compares the signature against an expected value, so a combinational block can be checked on silicon/FPGA without a simulator bench.

---
 rtl/truth_table_sweeper.sv | 108 ++++++++++
 tb/tb_truth_table_sweeper.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 3-input block through all 8 input combinations and captures its 8-bit truth table.
//   Parameters:
//     HOLD_CYCLES  clocks each combination is held (1..65535); f is sampled on the last one
//     EXP_TT       expected truth table, bit i = f for {x1,x2,x3} = i
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     start   sweep request, honoured only when idle
//     f       output of the block under test
//     x1..x3  stimulus, {x1,x2,x3} = current index while busy, else 000
//     busy    sweep in progress
//     done    one-cycle pulse after the final sample
//     tt_out  last captured truth table
//     match   tt_out == EXP_TT, updated together with tt_out
module truth_table_sweeper #(
    parameter int unsigned    HOLD_CYCLES = 20,
    parameter logic [7:0]     EXP_TT      = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_out,
    output logic       match
);

    // At least one bit so HOLD_CYCLES = 1 still has a legal counter.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    tt_q, tt_d;
    logic          match_q, match_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            tt_q     <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tt_q     <= tt_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        tt_d     = tt_q;
        match_d  = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            DRIVE: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d         = '0;
                    shadow_d[idx_q] = f;
                    if (idx_q == 3'd7) begin
                        // Final sample goes straight into the published table so
                        // tt_out/match change in one edge.
                        state_d = DONE;
                        tt_d    = shadow_d;
                        match_d = (shadow_d == EXP_TT);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so x changes only on clock edges.
    assign busy         = (state_q == DRIVE);
    assign done         = (state_q == DONE);
    assign {x1, x2, x3} = busy ? idx_q : 3'b000;
    assign tt_out       = tt_q;
    assign match        = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed scoreboard bench for truth_table_sweeper (HOLD_CYCLES 4 and 1).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic maj_mode = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   e0_a = 0;
    int   e0_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic xa1, xa2, xa3, busy_a, done_a, match_a, f_a;
    logic xb1, xb2, xb3, busy_b, done_b, match_b, f_b;
    logic [7:0] tt_a, tt_b;

    assign f_a = maj_mode & ((xa1 & xa2) | (xa1 & xa3) | (xa2 & xa3));
    assign f_b = xb3;

    truth_table_sweeper #(.HOLD_CYCLES(4), .EXP_TT(8'hE8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .f(f_a),
        .x1(xa1), .x2(xa2), .x3(xa3), .busy(busy_a), .done(done_a),
        .tt_out(tt_a), .match(match_a)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXP_TT(8'hE8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .f(f_b),
        .x1(xb1), .x2(xb2), .x3(xb3), .busy(busy_b), .done(done_b),
        .tt_out(tt_b), .match(match_b)
    );

    typedef struct {
        logic [7:0] tt;
        logic       m;
        int         at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: checks the stimulus index every busy cycle and pops the scoreboard on each done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (busy_a) chk("x_a", {29'd0, xa1, xa2, xa3}, {29'd0, 3'((cyc - e0_a) / 4)});
            if (busy_b) chk("x_b", {29'd0, xb1, xb2, xb3}, {29'd0, 3'((cyc - e0_b) % 10)});
            if (done_a) begin
                chk("done_a_expected", {31'd0, q_a.size() != 0}, 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("tt_a", {24'd0, tt_a}, {24'd0, e.tt});
                    chk("match_a", {31'd0, match_a}, {31'd0, e.m});
                    chk("done_a_cycle", cyc, e.at);
                    chk("x_a_after", {29'd0, xa1, xa2, xa3}, 32'd0);
                end
            end
            if (done_b) begin
                chk("done_b_expected", {31'd0, q_b.size() != 0}, 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("tt_b", {24'd0, tt_b}, {24'd0, e.tt});
                    chk("match_b", {31'd0, match_b}, {31'd0, e.m});
                    chk("done_b_cycle", cyc, e.at);
                end
            end
        end
    end

    // Issues a one-cycle start to dut_a; returns at the negedge right after E0.
    task automatic go_a(input logic [7:0] tt, input logic m);
        @(negedge clk);
        start_a = 1'b1;
        e0_a = cyc + 1;
        q_a.push_back('{tt: tt, m: m, at: cyc + 1 + 32});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values with start high
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", {29'd0, xa1, xa2, xa3}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_tt", {24'd0, tt_a}, 32'd0);
        chk("rst_match", {31'd0, match_a}, 32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        // 2: majority sweep
        maj_mode = 1'b1;
        go_a(8'hE8, 1'b1);
        repeat (40) @(negedge clk);
        chk("q_a_drained_maj", q_a.size(), 32'd0);
        // 3: f tied 0, then majority again; tt holds until the new completion
        maj_mode = 1'b0;
        go_a(8'h00, 1'b0);
        repeat (40) @(negedge clk);
        chk("q_a_drained_zero", q_a.size(), 32'd0);
        maj_mode = 1'b1;
        go_a(8'hE8, 1'b1);
        repeat (18) @(negedge clk);
        chk("tt_hold_mid", {24'd0, tt_a}, 32'd0);
        chk("match_hold_mid", {31'd0, match_a}, 32'd0);
        chk("busy_mid", {31'd0, busy_a}, 32'd1);
        repeat (22) @(negedge clk);
        chk("q_a_drained_rerun", q_a.size(), 32'd0);
        // 4: start pulse mid-sweep is ignored
        go_a(8'hE8, 1'b1);
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (30) @(negedge clk);
        chk("q_a_drained_midstart", q_a.size(), 32'd0);
        chk("busy_after_midstart", {31'd0, busy_a}, 32'd0);
        // 5: reset while idx = 4
        go_a(8'hE8, 1'b1);
        repeat (17) @(negedge clk);
        chk("pre_rst_idx", {29'd0, xa1, xa2, xa3}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_x", {29'd0, xa1, xa2, xa3}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_tt", {24'd0, tt_a}, 32'd0);
        chk("abort_match", {31'd0, match_a}, 32'd0);
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        go_a(8'hE8, 1'b1);
        repeat (40) @(negedge clk);
        chk("q_a_drained_after_rst", q_a.size(), 32'd0);
        // 6: HOLD_CYCLES = 1, f = x3, start held for back-to-back sweeps
        @(negedge clk);
        start_b = 1'b1;
        e0_b = cyc + 1;
        q_b.push_back('{tt: 8'hAA, m: 1'b0, at: cyc + 1 + 8});
        q_b.push_back('{tt: 8'hAA, m: 1'b0, at: cyc + 1 + 18});
        repeat (15) @(negedge clk);
        start_b = 1'b0;
        repeat (15) @(negedge clk);
        chk("q_b_drained", q_b.size(), 32'd0);
        chk("busy_b_end", {31'd0, busy_b}, 32'd0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
